// File: rtl/arbitro_estabelecidos_pkg.sv
// arbitro_estabelecidos_pkg: shared state encoding, default widths and slice helper.
package arbitro_estabelecidos_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 1;
    typedef enum logic {ST_ARB, ST_CLEAR} state_t;
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr: one-hot grant picker; round-robin from a pointer, or fixed priority
// (lowest index wins, no pointer) when ARB_FIXED_PRIO_EN is defined.
module arbitro_rr #(
    parameter int NUM_REQ = 4,
    parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx
);
`ifdef ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, en};
    always_comb begin
        grant = '0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant == '0 && req[i]) begin
                grant[i] = 1'b1;
                idx = PW'(i);
            end
    end
`else
    logic [PW-1:0] ptr;
    always_comb begin
        grant = '0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant == '0 && req[(int'(ptr) + i) % NUM_REQ]) begin
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                idx = PW'((int'(ptr) + i) % NUM_REQ);
            end
    end
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n)
            ptr <= '0;
        else if (en && grant != '0)
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
`endif
endmodule

// File: rtl/arbitro_estabelecidos.sv
// arbitro_estabelecidos: arbitrates the flag-memory write port among requesters and
// runs the clear sequence. Define ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module arbitro_estabelecidos
    import arbitro_estabelecidos_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            ack_out,
    input  logic                          clear_in,
    output logic                          busy_out,
    output logic                          clear_done_out,
    output logic                          mem_we_out,
    output logic [ADDR_WIDTH-1:0]         mem_waddr_out,
    output logic [DATA_WIDTH-1:0]         mem_wdata_out
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         gidx;
    logic                  arb_en;

    // a requester acked this cycle is masked so it cannot be re-granted back to back
    assign arb_en = state == ST_ARB && !clear_in;

    arbitro_rr #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (arb_en ? req_in & ~ack_out : '0),
        .grant (grant),
        .idx   (gidx)
    );

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            state <= ST_ARB;
            cnt <= '0;
            ack_out <= '0;
            busy_out <= 1'b0;
            clear_done_out <= 1'b0;
            mem_we_out <= 1'b0;
            mem_waddr_out <= '0;
            mem_wdata_out <= '0;
        end else begin
            ack_out <= '0;
            clear_done_out <= 1'b0;
            mem_wdata_out <= '0;
            if (state == ST_ARB) begin
                busy_out <= clear_in;
                mem_we_out <= clear_in || grant != '0;
                mem_waddr_out <= (!clear_in && grant != '0) ?
                    req_addr_in[slice_lo(int'(gidx), ADDR_WIDTH) +: ADDR_WIDTH] : '0;
                if (clear_in) begin
                    state <= ST_CLEAR;
                    cnt <= '0;
                end else begin
                    ack_out <= grant;
                    mem_wdata_out <= (grant != '0) ?
                        req_data_in[slice_lo(int'(gidx), DATA_WIDTH) +: DATA_WIDTH] : '0;
                end
            end else if (cnt == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                state <= ST_ARB;
                cnt <= '0;
                busy_out <= 1'b0;
                clear_done_out <= 1'b1;
                mem_we_out <= 1'b0;
                mem_waddr_out <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                mem_we_out <= 1'b1;
                mem_waddr_out <= cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_arbitro_estabelecidos.sv
// tb_arbitro_estabelecidos: directed table-driven check of arbitration plus
// hand-written clear and reset-mid-clear sequences.
module tb_arbitro_estabelecidos;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_in = '0;
    logic [31:0] req_addr_in = {8'h33, 8'h15, 8'h21, 8'h10};
    logic [3:0]  req_data_in = 4'b0101;
    logic [3:0]  ack_out;
    logic        clear_in = 1'b0;
    logic        busy_out, clear_done_out, mem_we_out;
    logic [7:0]  mem_waddr_out;
    logic [0:0]  mem_wdata_out;

    int passed = 0;
    int total = 0;

    arbitro_estabelecidos dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .ack_out(ack_out), .clear_in(clear_in),
        .busy_out(busy_out), .clear_done_out(clear_done_out), .mem_we_out(mem_we_out),
        .mem_waddr_out(mem_waddr_out), .mem_wdata_out(mem_wdata_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic       we;
        logic [7:0] waddr;
        logic       wdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ack, input logic we,
                           input logic [7:0] waddr, input logic wdata,
                           input logic busy, input logic done);
        chk({tag, ".ack"}, 32'(ack_out), 32'(ack));
        chk({tag, ".we"}, 32'(mem_we_out), 32'(we));
        chk({tag, ".waddr"}, 32'(mem_waddr_out), 32'(waddr));
        chk({tag, ".wdata"}, 32'(mem_wdata_out), 32'(wdata));
        chk({tag, ".busy"}, 32'(busy_out), 32'(busy));
        chk({tag, ".done"}, 32'(clear_done_out), 32'(done));
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[1]  = '{4'b1110, 4'b0010, 1'b1, 8'h21, 1'b0};
        vecs[2]  = '{4'b1100, 4'b0100, 1'b1, 8'h15, 1'b1};
        vecs[3]  = '{4'b1000, 4'b1000, 1'b1, 8'h33, 1'b0};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{4'b0100, 4'b0100, 1'b1, 8'h15, 1'b1};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[8]  = '{4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[10] = '{4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[12] = '{4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", 4'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        chk_all("post_reset", 4'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);

        // contention, single write, held request
        for (int i = 0; i < 14; i++) begin
            req_in = vecs[i].req;
            step();
            chk($sformatf("v%0d.ack", i), 32'(ack_out), 32'(vecs[i].ack));
            chk($sformatf("v%0d.we", i), 32'(mem_we_out), 32'(vecs[i].we));
            chk($sformatf("v%0d.waddr", i), 32'(mem_waddr_out), 32'(vecs[i].waddr));
            chk($sformatf("v%0d.wdata", i), 32'(mem_wdata_out), 32'(vecs[i].wdata));
        end

        // clear wins over a pending request, which is served after clear_done
        req_in = 4'b0010;
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk_all($sformatf("clr%0d", i), 4'b0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            step();
        end
        chk_all("clr_done", 4'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("clr_after", 4'b0010, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        req_in = 4'b0000;
        step();
        chk_all("clr_idle", 4'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);

        // reset mid-clear at cnt=10
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        repeat (10) step();
        chk_all("mid_cnt10", 4'b0, 1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        chk_all("mid_async", 4'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        chk_all("mid_release", 4'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        req_in = 4'b1111;
        step();
        chk_all("mid_ptr0", 4'b0001, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        req_in = 4'b0000;
        repeat (40) begin
            step();
            chk("mid_no_done", 32'(clear_done_out), 32'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
